quiz_round_controller: RTL and testbench

Round sequencer for the math-challenge game. It runs a fixed-length quiz: it requests a fresh operand pair from the operand/arithmetic datapath, runs a per-question countdown, compares the player's switch answer with the datapath's expected result, shows pass/fail feedback and keeps score. It sits between the board pushbuttons/switches, the slow-clock tick source, the operand generators/arithmetic unit, and the 7-segment/LED display drivers.

---
 rtl/quiz_round_controller.sv | 155 +++++++++++++++
 tb/tb_quiz_round_controller.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/quiz_round_controller.sv
// Round sequencer for the math-challenge game: requests operands, runs the per-question
// countdown, judges the switch answer against the latched datapath result and keeps score.
module quiz_round_controller #(
   parameter int ROUNDS         = 10,
   parameter int TIME_LIMIT     = 9,
   parameter int FEEDBACK_TICKS = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tick,
   input  logic       start_btn,
   input  logic       check_btn,
   input  logic [7:0] answer,
   input  logic [7:0] expected,
   input  logic       exp_valid,
   output logic       new_q,
   output logic [3:0] timer,
   output logic [3:0] round,
   output logic [3:0] score,
   output logic [9:0] lights,
   output logic       ok,
   output logic       bad,
   output logic       done
);

   localparam logic [3:0] ROUNDS_L  = 4'(ROUNDS);
   localparam logic [3:0] TIME_L    = 4'(TIME_LIMIT);
   localparam logic [3:0] FB_LAST_L = 4'(FEEDBACK_TICKS - 1);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      REQ      = 3'd1,
      WAIT_EXP = 3'd2,
      ANSWER   = 3'd3,
      FEEDBACK = 3'd4,
      DONE     = 3'd5
   } state_t;

   state_t     state;
   logic [1:0] start_sync;
   logic [1:0] check_sync;
   logic       start_prev;
   logic       check_prev;
   logic [7:0] exp_latched;
   logic [3:0] fb_cnt;
   logic       start_press;
   logic       check_press;

   // A press is the synchronized high-to-low transition, so a held button fires once.
   assign start_press = start_prev & ~start_sync[1];
   assign check_press = check_prev & ~check_sync[1];

   assign done = (state == DONE);

   always_comb begin
      lights = '0;
      for (int i = 0; i < 10; i++) begin
         lights[i] = (i < int'(score));
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         start_sync  <= 2'b11;
         check_sync  <= 2'b11;
         start_prev  <= 1'b1;
         check_prev  <= 1'b1;
         exp_latched <= '0;
         fb_cnt      <= '0;
         new_q       <= 1'b0;
         timer       <= '0;
         round       <= '0;
         score       <= '0;
         ok          <= 1'b0;
         bad         <= 1'b0;
      end else begin
         start_sync <= {start_sync[0], start_btn};
         check_sync <= {check_sync[0], check_btn};
         start_prev <= start_sync[1];
         check_prev <= check_sync[1];
         new_q      <= 1'b0;

         case (state)
            IDLE: begin
               if (start_press) begin
                  state <= REQ;
                  round <= 4'd1;
                  score <= '0;
                  new_q <= 1'b1;
               end
            end
            REQ: begin
               timer <= TIME_L;
               state <= WAIT_EXP;
            end
            WAIT_EXP: begin
               if (exp_valid) begin
                  exp_latched <= expected;
                  state       <= ANSWER;
               end
            end
            ANSWER: begin
               // A check press outranks an expiring tick in the same cycle.
               if (check_press) begin
                  fb_cnt <= '0;
                  state  <= FEEDBACK;
                  if (answer == exp_latched) begin
                     ok <= 1'b1;
                     if (score != ROUNDS_L) score <= score + 4'd1;
                  end else begin
                     bad <= 1'b1;
                  end
               end else if (tick) begin
                  if (timer == 4'd1) begin
                     timer  <= '0;
                     bad    <= 1'b1;
                     fb_cnt <= '0;
                     state  <= FEEDBACK;
                  end else begin
                     timer <= timer - 4'd1;
                  end
               end
            end
            FEEDBACK: begin
               if (tick) begin
                  if (fb_cnt == FB_LAST_L) begin
                     ok  <= 1'b0;
                     bad <= 1'b0;
                     if (round == ROUNDS_L) begin
                        state <= DONE;
                     end else begin
                        round <= round + 4'd1;
                        new_q <= 1'b1;
                        state <= REQ;
                     end
                  end else begin
                     fb_cnt <= fb_cnt + 4'd1;
                  end
               end
            end
            DONE: begin
               if (start_press) begin
                  score <= '0;
                  round <= 4'd1;
                  new_q <= 1'b1;
                  state <= REQ;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_quiz_round_controller.sv
// Directed bench for quiz_round_controller: answer judging, timeout, check-vs-tick race,
// ignored inputs, mid-game reset, a full ten-round game and held-button behaviour.
module tb_quiz_round_controller;

   logic       clk;
   logic       reset;
   logic       tick;
   logic       start_btn;
   logic       check_btn;
   logic [7:0] answer;
   logic [7:0] expected;
   logic       exp_valid;
   logic       new_q;
   logic [3:0] timer;
   logic [3:0] round;
   logic [3:0] score;
   logic [9:0] lights;
   logic       ok;
   logic       bad;
   logic       done;

   int checks   = 0;
   int failures = 0;

   quiz_round_controller #(.ROUNDS(10), .TIME_LIMIT(9), .FEEDBACK_TICKS(2)) dut (
      .clk(clk), .reset(reset), .tick(tick), .start_btn(start_btn), .check_btn(check_btn),
      .answer(answer), .expected(expected), .exp_valid(exp_valid), .new_q(new_q),
      .timer(timer), .round(round), .score(score), .lights(lights), .ok(ok), .bad(bad),
      .done(done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Inputs change and outputs are sampled on the falling edge.
   task automatic give_tick();
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
   endtask

   task automatic give_exp(input logic [7:0] v);
      expected  = v;
      exp_valid = 1'b1;
      @(negedge clk);
      exp_valid = 1'b0;
   endtask

   // Returns on the falling edge just after the edge that consumes the press.
   task automatic press(input bit is_start, input bit with_tick);
      if (is_start) start_btn = 1'b0; else check_btn = 1'b0;
      @(negedge clk);
      @(negedge clk);
      tick = with_tick;
      @(negedge clk);
      tick = 1'b0;
      start_btn = 1'b1;
      check_btn = 1'b1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_reset();
      do_reset();
      @(negedge clk);
      checks++; if ({new_q, timer, round, score, lights, ok, bad, done} !== 27'd0) begin failures++; $display("FAIL reset_outputs got=%h want=0", {new_q, timer, round, score, lights, ok, bad, done}); end
      reset = 1'b0;
      @(negedge clk);
      press(1'b0, 1'b0);
      repeat (2) @(negedge clk);
      checks++; if ({round, ok, bad, new_q} !== 7'd0) begin failures++; $display("FAIL idle_check_ignored got=%h want=0", {round, ok, bad, new_q}); end
   endtask

   task automatic test_correct();
      press(1'b1, 1'b0);
      checks++; if (new_q !== 1'b1 || round !== 4'd1) begin failures++; $display("FAIL start_req new_q=%b round=%0d want 1/1", new_q, round); end
      @(negedge clk);
      checks++; if (new_q !== 1'b0 || timer !== 4'd9) begin failures++; $display("FAIL new_q_one_cycle new_q=%b timer=%0d want 0/9", new_q, timer); end
      give_exp(8'd12);
      answer = 8'd12;
      press(1'b0, 1'b0);
      checks++; if (ok !== 1'b1 || bad !== 1'b0 || score !== 4'd1 || lights !== 10'b0000000001) begin failures++; $display("FAIL correct_answer ok=%b bad=%b score=%0d lights=%b want 1/0/1/0000000001", ok, bad, score, lights); end
      give_tick();
      checks++; if (ok !== 1'b1 || new_q !== 1'b0) begin failures++; $display("FAIL feedback_hold ok=%b new_q=%b want 1/0", ok, new_q); end
      give_tick();
      checks++; if (ok !== 1'b0 || round !== 4'd2 || new_q !== 1'b1) begin failures++; $display("FAIL next_round ok=%b round=%0d new_q=%b want 0/2/1", ok, round, new_q); end
      @(negedge clk);
   endtask

   task automatic test_wrong_and_timeout();
      give_exp(8'd7);
      expected = 8'd6;
      answer   = 8'd6;
      press(1'b0, 1'b0);
      checks++; if (bad !== 1'b1 || ok !== 1'b0 || score !== 4'd1) begin failures++; $display("FAIL wrong_answer bad=%b ok=%b score=%0d want 1/0/1", bad, ok, score); end
      repeat (2) give_tick();
      checks++; if (bad !== 1'b0 || round !== 4'd3 || new_q !== 1'b1) begin failures++; $display("FAIL after_wrong bad=%b round=%0d new_q=%b want 0/3/1", bad, round, new_q); end
      @(negedge clk);
      give_exp(8'd5);
      for (int k = 1; k <= 8; k++) begin
         give_tick();
         checks++; if (timer !== 4'(9 - k) || bad !== 1'b0) begin failures++; $display("FAIL countdown timer=%0d bad=%b want %0d/0", timer, bad, 9 - k); end
      end
      give_tick();
      checks++; if (timer !== 4'd0 || bad !== 1'b1 || ok !== 1'b0 || score !== 4'd1) begin failures++; $display("FAIL timeout timer=%0d bad=%b ok=%b score=%0d want 0/1/0/1", timer, bad, ok, score); end
      repeat (2) give_tick();
      checks++; if (round !== 4'd4 || new_q !== 1'b1) begin failures++; $display("FAIL after_timeout round=%0d new_q=%b want 4/1", round, new_q); end
      @(negedge clk);
   endtask

   task automatic test_check_vs_tick();
      give_exp(8'd33);
      answer = 8'd33;
      repeat (8) give_tick();
      checks++; if (timer !== 4'd1) begin failures++; $display("FAIL pre_race_timer got=%0d want 1", timer); end
      press(1'b0, 1'b1);
      checks++; if (ok !== 1'b1 || bad !== 1'b0 || timer !== 4'd1 || score !== 4'd2) begin failures++; $display("FAIL check_wins ok=%b bad=%b timer=%0d score=%0d want 1/0/1/2", ok, bad, timer, score); end
      repeat (2) give_tick();
      @(negedge clk);
   endtask

   task automatic test_ignored();
      repeat (3) give_tick();
      checks++; if (timer !== 4'd9) begin failures++; $display("FAIL wait_exp_ticks timer=%0d want 9", timer); end
      press(1'b0, 1'b0);
      checks++; if (ok !== 1'b0 || bad !== 1'b0) begin failures++; $display("FAIL wait_exp_check ok=%b bad=%b want 0/0", ok, bad); end
      give_exp(8'd40);
      answer = 8'd40;
      press(1'b1, 1'b0);
      checks++; if (new_q !== 1'b0 || round !== 4'd5) begin failures++; $display("FAIL answer_start_ignored new_q=%b round=%0d want 0/5", new_q, round); end
      press(1'b0, 1'b0);
      checks++; if (ok !== 1'b1 || score !== 4'd3 || lights !== 10'b0000000111) begin failures++; $display("FAIL third_correct ok=%b score=%0d lights=%b want 1/3/0000000111", ok, score, lights); end
      repeat (2) give_tick();
      // exp_valid coinciding with the request cycle must not be taken.
      give_exp(8'd50);
      give_tick();
      checks++; if (timer !== 4'd9) begin failures++; $display("FAIL exp_with_new_q timer=%0d want 9", timer); end
   endtask

   task automatic test_reset_mid();
      give_exp(8'd1);
      repeat (4) give_tick();
      checks++; if (timer !== 4'd5 || score !== 4'd3) begin failures++; $display("FAIL pre_reset timer=%0d score=%0d want 5/3", timer, score); end
      do_reset();
      checks++; if ({new_q, timer, round, score, lights, ok, bad, done} !== 27'd0) begin failures++; $display("FAIL reset_mid got=%h want=0", {new_q, timer, round, score, lights, ok, bad, done}); end
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_full_game();
      press(1'b1, 1'b0);
      for (int r = 1; r <= 10; r++) begin
         @(negedge clk);
         give_exp(8'(r * 3));
         answer = 8'(r * 3);
         press(1'b0, 1'b0);
         checks++; if (ok !== 1'b1 || score !== 4'(r)) begin failures++; $display("FAIL game_round r=%0d ok=%b score=%0d want 1/%0d", r, ok, score, r); end
         repeat (2) give_tick();
         checks++; if (new_q !== (r < 10) || round !== 4'((r < 10) ? r + 1 : 10) || done !== (r == 10)) begin failures++; $display("FAIL game_advance r=%0d new_q=%b round=%0d done=%b", r, new_q, round, done); end
      end
      checks++; if (done !== 1'b1 || score !== 4'd10 || lights !== 10'h3FF) begin failures++; $display("FAIL game_done done=%b score=%0d lights=%h want 1/10/3ff", done, score, lights); end
      check_btn = 1'b0;
      repeat (100) @(negedge clk);
      check_btn = 1'b1;
      repeat (3) @(negedge clk);
      checks++; if (done !== 1'b1 || score !== 4'd10 || round !== 4'd10 || ok !== 1'b0 || bad !== 1'b0) begin failures++; $display("FAIL done_hold done=%b score=%0d round=%0d ok=%b bad=%b", done, score, round, ok, bad); end
      press(1'b1, 1'b0);
      checks++; if (new_q !== 1'b1 || score !== 4'd0 || round !== 4'd1 || done !== 1'b0) begin failures++; $display("FAIL restart new_q=%b score=%0d round=%0d done=%b want 1/0/1/0", new_q, score, round, done); end
   endtask

   task automatic test_hold_start();
      int pulses;
      do_reset();
      reset = 1'b0;
      @(negedge clk);
      pulses = 0;
      start_btn = 1'b0;
      repeat (1000) begin
         @(negedge clk);
         if (new_q) pulses++;
      end
      start_btn = 1'b1;
      checks++; if (pulses !== 1) begin failures++; $display("FAIL held_start pulses=%0d want 1", pulses); end
      repeat (4) give_tick();
      checks++; if (timer !== 4'd9 || round !== 4'd1) begin failures++; $display("FAIL held_wait_exp timer=%0d round=%0d want 9/1", timer, round); end
   endtask

   initial begin
      reset = 1'b1; tick = 1'b0; start_btn = 1'b1; check_btn = 1'b1;
      answer = '0; expected = '0; exp_valid = 1'b0;
      @(negedge clk);
      test_reset();
      test_correct();
      test_wrong_and_timeout();
      test_check_vs_tick();
      test_ignored();
      test_reset_mid();
      test_full_game();
      test_hold_start();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog time limit reached");
      $fatal(1);
   end

endmodule
